// File: rtl/falafel_alloc_fsm_pkg.sv
// Package for the falafel first-fit allocator.
// Holds the LSU request/response types the allocator drives, the allocator
// state enum, the null address and align_size(), which rounds a request up
// to the allocation granularity and applies the minimum-block floor.
package falafel_alloc_fsm_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ALLOC_NULL_ADDR = '0;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    INSERT = 2'd1,
    DELETE = 2'd2
  } lsu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_data_t;

  typedef struct packed {
    logic         val;
    lsu_op_e      lsu_op;
    header_data_t header_data;
  } header_data_req_t;

  typedef struct packed {
    logic         val;
    header_data_t header_data;
  } header_data_rsp_t;

  typedef enum logic [2:0] {
    ALLOC_IDLE,
    ALLOC_REQ_LOAD,
    ALLOC_WAIT_LOAD,
    ALLOC_SPLIT,
    ALLOC_UNLINK,
    ALLOC_WAIT_STORE,
    ALLOC_RESP
  } alloc_state_e;

  // Result is one bit wider than the data path: bit DATA_W set means the
  // rounding overflowed and the request cannot be satisfied.
  function automatic logic [DATA_W:0] align_size(input logic [DATA_W-1:0] size,
                                                 input logic [DATA_W:0]   align,
                                                 input logic [DATA_W:0]   min_split);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] asz;
    sum = {1'b0, size} + align - (DATA_W+1)'(1);
    asz = sum & ~(align - (DATA_W+1)'(1));
    if (asz < min_split) asz = min_split;
    return asz;
  endfunction

endpackage

// File: rtl/falafel_alloc_fsm_if.sv
// Core-side allocation port of the falafel allocator.
//   alloc_req_val/rdy/size : allocation request handshake and byte count
//   alloc_rsp_val/rdy      : result handshake
//   alloc_rsp_addr/err     : allocated address (0 on failure) and error flag
// master = the core issuing requests, slave = the allocator.
interface falafel_alloc_fsm_if;
  import falafel_alloc_fsm_pkg::*;

  logic              alloc_req_val;
  logic              alloc_req_rdy;
  logic [DATA_W-1:0] alloc_req_size;
  logic              alloc_rsp_val;
  logic              alloc_rsp_rdy;
  logic [DATA_W-1:0] alloc_rsp_addr;
  logic              alloc_rsp_err;

  modport master (
    output alloc_req_val, alloc_req_size, alloc_rsp_rdy,
    input  alloc_req_rdy, alloc_rsp_val, alloc_rsp_addr, alloc_rsp_err
  );

  modport slave (
    input  alloc_req_val, alloc_req_size, alloc_rsp_rdy,
    output alloc_req_rdy, alloc_rsp_val, alloc_rsp_addr, alloc_rsp_err
  );

endinterface

// File: rtl/falafel_alloc_fsm.sv
// First-fit allocation engine in front of the falafel LSU.
// Walks the singly linked free list starting at the sentinel HEAD_ADDR with
// one LSU LOAD per block, then either shrinks the chosen block (INSERT with
// the remainder size; the caller gets the tail) or unlinks it by rewriting
// the predecessor's next pointer (DELETE), and reports the address.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   alloc          : core request/response port (falafel_alloc_fsm_if.slave)
//   lsu_req_o      : request to the LSU (val, op, header data)
//   lsu_ready_i    : LSU can take a request
//   lsu_rsp_i      : LSU response
//   lsu_rsp_rdy_o  : allocator is waiting for an LSU response
// Optional FALAFEL_ALLOC_STATS_EN adds stat_ok_cnt_o, stat_fail_cnt_o and
// stat_max_walk_o.
module falafel_alloc_fsm
  import falafel_alloc_fsm_pkg::*;
#(
  parameter logic [DATA_W-1:0] HEAD_ADDR = 32'h0000_1000,
  parameter int unsigned       ALIGN     = 8,
  parameter int unsigned       MIN_SPLIT = 32,
  parameter int unsigned       MAX_WALK  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  falafel_alloc_fsm_if.slave     alloc,
  output header_data_req_t       lsu_req_o,
  input  logic                   lsu_ready_i,
  input  header_data_rsp_t       lsu_rsp_i,
  output logic                   lsu_rsp_rdy_o
`ifdef FALAFEL_ALLOC_STATS_EN
  ,
  output logic [31:0]            stat_ok_cnt_o,
  output logic [31:0]            stat_fail_cnt_o,
  output logic [31:0]            stat_max_walk_o
`endif
);

  localparam logic [DATA_W:0]   ALIGN_W     = (DATA_W+1)'(ALIGN);
  localparam logic [DATA_W:0]   MIN_SPLIT_W = (DATA_W+1)'(MIN_SPLIT);
  localparam logic [DATA_W-1:0] MIN_SPLIT_D = DATA_W'(MIN_SPLIT);
  localparam logic [31:0]       MAX_WALK_D  = 32'(MAX_WALK);

  alloc_state_e      state_q, state_d;
  logic [DATA_W-1:0] asz_q, asz_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] blk_size_q, blk_size_d;
  logic [DATA_W-1:0] next_q, next_d;
  logic [31:0]       walk_q, walk_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] res_addr_q, res_addr_d;
  logic              err_q, err_d;

  logic [DATA_W:0]   asz_full;
  logic [DATA_W-1:0] remainder;
  logic              fits;

  // The response carries the block address back; the allocator already
  // knows it, so it is deliberately ignored.
  logic unused_rsp_addr;
  assign unused_rsp_addr = ^lsu_rsp_i.header_data.addr;

  // State and datapath registers; reset abandons any walk in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ALLOC_IDLE;
      asz_q      <= '0;
      cur_q      <= '0;
      prev_q     <= '0;
      blk_size_q <= '0;
      next_q     <= '0;
      walk_q     <= '0;
      first_q    <= 1'b0;
      res_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      asz_q      <= asz_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      blk_size_q <= blk_size_d;
      next_q     <= next_d;
      walk_q     <= walk_d;
      first_q    <= first_d;
      res_addr_q <= res_addr_d;
      err_q      <= err_d;
    end
  end

  // Next state, datapath updates and outputs. Outputs depend only on
  // registered state so they stay stable while a handshake is pending.
  always_comb begin
    state_d    = state_q;
    asz_d      = asz_q;
    cur_d      = cur_q;
    prev_d     = prev_q;
    blk_size_d = blk_size_q;
    next_d     = next_q;
    walk_d     = walk_q;
    first_d    = first_q;
    res_addr_d = res_addr_q;
    err_d      = err_q;

    alloc.alloc_req_rdy  = 1'b0;
    alloc.alloc_rsp_val  = 1'b0;
    alloc.alloc_rsp_addr = '0;
    alloc.alloc_rsp_err  = 1'b0;
    lsu_req_o            = '0;
    lsu_rsp_rdy_o        = 1'b0;

    asz_full  = align_size(alloc.alloc_req_size, ALIGN_W, MIN_SPLIT_W);
    remainder = lsu_rsp_i.header_data.size - asz_q;
    fits      = lsu_rsp_i.header_data.size >= asz_q;

    unique case (state_q)
      ALLOC_IDLE: begin
        // Masked by reset so every output reads 0 while reset is held.
        alloc.alloc_req_rdy = !rst_i;
        if (alloc.alloc_req_val) begin
          prev_d     = HEAD_ADDR;
          cur_d      = HEAD_ADDR;
          walk_d     = '0;
          first_d    = 1'b1;
          res_addr_d = ALLOC_NULL_ADDR;
          if (alloc.alloc_req_size == '0 || asz_full[DATA_W]) begin
            err_d   = 1'b1;
            state_d = ALLOC_RESP;
          end else begin
            asz_d   = asz_full[DATA_W-1:0];
            err_d   = 1'b0;
            state_d = ALLOC_REQ_LOAD;
          end
        end
      end

      ALLOC_REQ_LOAD: begin
        lsu_req_o.val              = 1'b1;
        lsu_req_o.lsu_op           = LOAD;
        lsu_req_o.header_data.addr = cur_q;
        if (lsu_ready_i) state_d = ALLOC_WAIT_LOAD;
      end

      ALLOC_WAIT_LOAD: begin
        lsu_rsp_rdy_o = 1'b1;
        if (lsu_rsp_i.val) begin
          blk_size_d = lsu_rsp_i.header_data.size;
          next_d     = lsu_rsp_i.header_data.next_addr;
          if (first_q) begin
            // The sentinel only supplies the first real block; it is never a candidate.
            first_d = 1'b0;
            cur_d   = lsu_rsp_i.header_data.next_addr;
            if (lsu_rsp_i.header_data.next_addr == ALLOC_NULL_ADDR) begin
              err_d   = 1'b1;
              state_d = ALLOC_RESP;
            end else begin
              state_d = ALLOC_REQ_LOAD;
            end
          end else if (fits && remainder >= MIN_SPLIT_D) begin
            // Hand out the tail so the free block keeps its address and link.
            res_addr_d = cur_q + remainder;
            state_d    = ALLOC_SPLIT;
          end else if (fits) begin
            res_addr_d = cur_q;
            state_d    = ALLOC_UNLINK;
          end else begin
            prev_d = cur_q;
            cur_d  = lsu_rsp_i.header_data.next_addr;
            walk_d = walk_q + 32'd1;
            if (lsu_rsp_i.header_data.next_addr == ALLOC_NULL_ADDR || walk_d == MAX_WALK_D) begin
              res_addr_d = ALLOC_NULL_ADDR;
              err_d      = 1'b1;
              state_d    = ALLOC_RESP;
            end else begin
              state_d = ALLOC_REQ_LOAD;
            end
          end
        end
      end

      ALLOC_SPLIT: begin
        lsu_req_o.val                   = 1'b1;
        lsu_req_o.lsu_op                = INSERT;
        lsu_req_o.header_data.addr      = cur_q;
        lsu_req_o.header_data.size      = blk_size_q - asz_q;
        lsu_req_o.header_data.next_addr = next_q;
        if (lsu_ready_i) state_d = ALLOC_WAIT_STORE;
      end

      ALLOC_UNLINK: begin
        lsu_req_o.val                   = 1'b1;
        lsu_req_o.lsu_op                = DELETE;
        lsu_req_o.header_data.addr      = prev_q;
        lsu_req_o.header_data.next_addr = next_q;
        if (lsu_ready_i) state_d = ALLOC_WAIT_STORE;
      end

      ALLOC_WAIT_STORE: begin
        lsu_rsp_rdy_o = 1'b1;
        if (lsu_rsp_i.val) begin
          err_d   = 1'b0;
          state_d = ALLOC_RESP;
        end
      end

      ALLOC_RESP: begin
        alloc.alloc_rsp_val  = 1'b1;
        alloc.alloc_rsp_addr = res_addr_q;
        alloc.alloc_rsp_err  = err_q;
        if (alloc.alloc_rsp_rdy) state_d = ALLOC_IDLE;
      end

      default: state_d = ALLOC_IDLE;
    endcase
  end

`ifdef FALAFEL_ALLOC_STATS_EN
  // Outcome counters advance on the result handshake; the walk high-water
  // mark follows the walk counter as it is updated.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_ok_cnt_o   <= '0;
      stat_fail_cnt_o <= '0;
      stat_max_walk_o <= '0;
    end else begin
      if (state_q == ALLOC_RESP && alloc.alloc_rsp_rdy) begin
        if (err_q) stat_fail_cnt_o <= stat_fail_cnt_o + 32'd1;
        else       stat_ok_cnt_o   <= stat_ok_cnt_o + 32'd1;
      end
      if (walk_d > stat_max_walk_o) stat_max_walk_o <= walk_d;
    end
  end
`endif

endmodule

// File: doc/falafel_alloc_fsm.md
Name: falafel_alloc_fsm

Overview:
First-fit allocation engine that sits directly upstream of the falafel LSU and drives its core-side request/response port. It accepts an allocation size from the core and walks the singly linked free list, one LSU LOAD per block. It then either shrinks the chosen block with an INSERT (split) or unlinks it with a DELETE on its predecessor, and returns the allocated address to the core.

Parameters:
HEAD_ADDR, 32'h0000_1000, address of the sentinel head block; its next_addr is the first free block.
ALIGN, 8, allocation granularity in bytes; must be a power of two.
MIN_SPLIT, 32, smallest remainder that is left as a free block; a smaller remainder means the whole block is handed out.
MAX_WALK, 1024, maximum number of blocks visited before the request fails.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
alloc_req_val_i  in  1  core allocation request valid
alloc_req_rdy_o  out  1  block can accept a request
alloc_req_size_i  in  DATA_W  requested bytes
alloc_rsp_val_o  out  1  result valid
alloc_rsp_rdy_i  in  1  core accepts result
alloc_rsp_addr_o  out  DATA_W  allocated address; 0 on failure
alloc_rsp_err_o  out  1  allocation failed
lsu_req_o  out  header_data_req_t  request to LSU (val, lsu_op, header_data)
lsu_ready_i  in  1  LSU ready/idle
lsu_rsp_i  in  header_data_rsp_t  LSU response (val, header_data)
lsu_rsp_rdy_o  out  1  drives the LSU's core_rdy_i

Behaviour:
- One clock and one reset: asynchronous, active-high (clk_i, rst_i). On reset the block goes to IDLE and every output is 0; all registers clear.
- Reset mid-operation abandons the walk and does not complete any split or unlink. The LSU must be reset in the same domain.
- LSU handshake: lsu_req_o.val is held with stable content until a cycle with lsu_req_o.val && lsu_ready_i. The next cycle it deasserts.
- lsu_rsp_rdy_o is 1 only in wait states. A response is consumed when lsu_rsp_i.val && lsu_rsp_rdy_o.
- Core handshake: a request is accepted on alloc_req_val_i && alloc_req_rdy_o; alloc_req_rdy_o=1 only in IDLE.
- The result is held until alloc_rsp_rdy_i, then the block returns to IDLE. Earliest next accept is the following cycle.
- Size rule: asz = (size + ALIGN-1) & ~(ALIGN-1), computed at DATA_W+1 bits; if asz < MIN_SPLIT then asz = MIN_SPLIT.
- size==0 or a carry out of the rounding: go straight to RESP with err=1 and addr=0; no LSU traffic.
- States:
  - IDLE: on accept, latch asz; prev=HEAD_ADDR; walk=0; go to REQ_LOAD with addr=HEAD_ADDR.
  - REQ_LOAD: issue LOAD with header_data.addr=cur, then go to WAIT_LOAD.
  - WAIT_LOAD: latch rsp size and next_addr. First load (head): cur=next. If cur==0, fail; else go to REQ_LOAD.
  - WAIT_LOAD, later loads, in priority order:
    - size >= asz and size-asz >= MIN_SPLIT: SPLIT.
    - size >= asz: UNLINK.
    - Otherwise prev=cur, cur=next, walk++. Fail if next==0 or walk==MAX_WALK; else go to REQ_LOAD.
  - SPLIT: issue INSERT with addr=cur, size=size-asz, next_addr=latched next. Result addr = cur + size - asz.
  - UNLINK: issue DELETE with addr=prev, next_addr=latched next. Result addr = cur.
  - WAIT_STORE: wait for the LSU response, then go to RESP with err=0.
  - RESP: drive alloc_rsp_val_o=1 with the addr/err registers.
- Unsigned size compare; equality counts as fit. The head block itself is never allocated.
- LOCK is not issued; mutual exclusion is the caller's responsibility.

Optional Feature:
FALAFEL_ALLOC_STATS_EN:
- Defined: adds outputs stat_ok_cnt_o, stat_fail_cnt_o and stat_max_walk_o (each 32 bits, reset 0). The two counters increment once per RESP handshake, ok or fail. stat_max_walk_o holds the largest walk value reached.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- falafel_pkg gains the alloc_state_e enum and ALLOC_NULL_ADDR (0).
- It reuses header_data_req_t/rsp_t, DATA_W and the LSU op enum (LOAD/INSERT/DELETE).
- No sub-module; the size rounding is a package function, align_size().

Test Plan:
- Free list: HEAD(0x1000)->A(0x2000, 0x40)->B(0x3000, 0x100)->0, defaults. Test 1: request 0x20 -> LOAD 0x1000, LOAD 0x2000, INSERT addr 0x2000 size 0x20; rsp addr 0x2020, err 0.
- Same list, request 0x30 -> remainder 0x10 < MIN_SPLIT; DELETE addr 0x1000 next 0x3000; rsp addr 0x2000.
- Request 0x41 -> asz 0x48; A skipped; INSERT addr 0x3000 size 0xB8; rsp addr 0x30B8.
- Request 0x200 -> three LOADs, no store; rsp err 1, addr 0.
- Request 0 -> rsp err 1 after the accept, lsu_req_o.val never asserts. Also hold alloc_rsp_rdy_i=0 for 5 cycles: val, addr and err stay stable.
- Assert rst_i in WAIT_LOAD -> all outputs 0 asynchronously. The next request after release completes normally; LSU ready stalls of 3 cycles do not duplicate requests.
